// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add multiplier with pipeline stall/done handshake
module mul_sequencer #(
    parameter int DATA_W     = 64,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    stall   = 1'b1;
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (EARLY_EXIT && (b_q == '0)) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    // The last iteration's add must land in the result register too.
                    if (cnt_q == CNT_LAST) begin
                        result_d = acc_d;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - randomized self-checking bench for mul_sequencer (both exit modes)
module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         arst;
    logic         start  [2];
    logic         flush  [2];
    logic [W-1:0] op_a   [2];
    logic [W-1:0] op_b   [2];
    logic         stall  [2];
    logic         done   [2];
    logic [W-1:0] result [2];
    logic [W-1:0] last_res [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.DATA_W(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .arst(arst), .start(start[0]), .op_a(op_a[0]), .op_b(op_b[0]),
        .flush(flush[0]), .stall(stall[0]), .done(done[0]), .result(result[0])
    );

    mul_sequencer #(.DATA_W(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .arst(arst), .start(start[1]), .op_a(op_a[1]), .op_b(op_b[1]),
        .flush(flush[1]), .stall(stall[1]), .done(done[1]), .result(result[1])
    );

    // Cycles from the accepting cycle to the done cycle; dut0 never exits early.
    function automatic int lat(input int i, input logic [W-1:0] b);
        int h;
        if (i == 0) return W + 1;
        if (b == '0) return 2;
        h = 0;
        for (int j = 0; j < W; j++) if (b[j]) h = j;
        return (h + 3 < W + 1) ? h + 3 : W + 1;
    endfunction

    task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int fk);
        int l;
        logic [W-1:0] expv;
        l = lat(i, b);
        expv = a * b;
        for (int k = 0; k <= l + 1; k++) begin
            @(negedge clk);
            start[i] = (k == 0);
            flush[i] = (k == fk);
            op_a[i]  = (k == 0) ? a : W'($urandom);
            op_b[i]  = (k == 0) ? b : W'($urandom);
            #1;
            checks++;
            if (stall[i] !== (k < l)) begin
                errors++;
                $display("FAIL op_stall dut%0d a=%h b=%h k=%0d: got %b want %b", i, a, b, k, stall[i], (k < l));
            end
            checks++;
            if (done[i] !== (k == l)) begin
                errors++;
                $display("FAIL op_done dut%0d a=%h b=%h k=%0d: got %b want %b", i, a, b, k, done[i], (k == l));
            end
            if (k == l) begin
                checks++;
                if (result[i] !== expv) begin
                    errors++;
                    $display("FAIL op_result dut%0d a=%h b=%h: got %h want %h", i, a, b, result[i], expv);
                end
                last_res[i] = expv;
            end
        end
        flush[i] = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; flush[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; last_res[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({stall[i], done[i], result[i]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got stall=%b done=%b result=%h want all 0", i, stall[i], done[i], result[i]);
            end
        end
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_basic();
        run_op(0, 32'd7, 32'd6, -1);
        run_op(1, 32'd7, 32'd6, -1);
    endtask

    task automatic test_early_exit();
        run_op(1, 32'h1234_5678, 32'd0, -1);
        run_op(1, 32'hDEAD_BEEF, 32'd1, -1);
        run_op(0, 32'h1234_5678, 32'd0, -1);
    endtask

    task automatic test_corners();
        for (int i = 0; i < 2; i++) begin
            run_op(i, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
            run_op(i, 32'h8000_0000, 32'd2, -1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 2; i++) begin
                run_op(i, W'($urandom), W'($urandom) >> $urandom_range(0, 31), -1);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k <= 40; k++) begin
                @(negedge clk);
                start[i] = (k == 0);
                flush[i] = (k == 5);
                op_a[i]  = W'($urandom);
                op_b[i]  = 32'h8000_0000 | W'($urandom);
                #1;
                checks++;
                if (stall[i] !== (k <= 5)) begin
                    errors++;
                    $display("FAIL flush_stall dut%0d k=%0d: got %b want %b", i, k, stall[i], (k <= 5));
                end
                checks++;
                if (done[i] !== 1'b0 || result[i] !== last_res[i]) begin
                    errors++;
                    $display("FAIL flush_nodone dut%0d k=%0d: got done=%b result=%h want done=0 result=%h", i, k, done[i], result[i], last_res[i]);
                end
            end
            for (int k = 0; k <= 36; k++) begin
                @(negedge clk);
                start[i] = (k == 0);
                flush[i] = (k == 0);
                #1;
                checks++;
                if (stall[i] !== 1'b0 || done[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_start dut%0d k=%0d: got stall=%b done=%b want 0 0", i, k, stall[i], done[i]);
                end
            end
            flush[i] = 1'b0;
            // Flush landing in the done cycle must not revoke the result.
            run_op(i, W'($urandom), 32'd1, lat(i, 32'd1));
        end
    endtask

    task automatic test_back_to_back();
        int l1, l2, tot;
        logic exp_stall, exp_done;
        for (int i = 0; i < 2; i++) begin
            l1 = lat(i, 32'd5);
            l2 = lat(i, 32'd9);
            tot = l1 + 1 + l2;
            for (int k = 0; k <= tot + 1; k++) begin
                @(negedge clk);
                start[i] = (k <= l1 + 1);
                if (k == 0) begin
                    op_a[i] = 32'd3; op_b[i] = 32'd5;
                end else if (k == l1 + 1) begin
                    op_a[i] = 32'd9; op_b[i] = 32'd9;
                end else begin
                    op_a[i] = W'($urandom); op_b[i] = W'($urandom);
                end
                #1;
                exp_stall = (k < l1) || (k >= l1 + 1 && k < tot);
                exp_done  = (k == l1) || (k == tot);
                checks++;
                if (stall[i] !== exp_stall) begin
                    errors++;
                    $display("FAIL b2b_stall dut%0d k=%0d: got %b want %b", i, k, stall[i], exp_stall);
                end
                checks++;
                if (done[i] !== exp_done) begin
                    errors++;
                    $display("FAIL b2b_done dut%0d k=%0d: got %b want %b", i, k, done[i], exp_done);
                end
                if (k == l1 || k == tot) begin
                    checks++;
                    if (result[i] !== ((k == l1) ? 32'd15 : 32'd81)) begin
                        errors++;
                        $display("FAIL b2b_result dut%0d k=%0d: got %0d want %0d", i, k, result[i], (k == l1) ? 15 : 81);
                    end
                end
            end
            last_res[i] = 32'd81;
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b1; op_a[i] = 32'h1234_5678; op_b[i] = 32'h8765_4321;
        end
        @(negedge clk);
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 arst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({stall[i], done[i], result[i]} !== '0) begin
                errors++;
                $display("FAIL midrun_reset dut%0d: got stall=%b done=%b result=%h want all 0", i, stall[i], done[i], result[i]);
            end
            last_res[i] = '0;
        end
        @(negedge clk);
        arst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (done[i] !== 1'b0 || stall[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset_idle dut%0d k=%0d: got done=%b stall=%b want 0 0", i, k, done[i], stall[i]);
                end
            end
        end
        run_op(0, 32'd2, 32'd3, -1);
        run_op(1, 32'd2, 32'd3, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_exit();
        test_corners();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
